// File: rtl/ifetch_if.sv
// ifetch_if: decoder-side issue signals and memory-controller refill bus of the fetch unit
interface ifetch_if;
  logic inst_done;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic pre_j;
  logic issue_stall;
  logic mc_req;
  logic [31:0] mc_addr;
  logic mc_done;
  logic [127:0] mc_data;
  modport master (
    output inst_done, inst, inst_pc, pre_j, mc_req, mc_addr,
    input issue_stall, mc_done, mc_data
  );
  modport slave (
    input inst_done, inst, inst_pc, pre_j, mc_req, mc_addr,
    output issue_stall, mc_done, mc_data
  );
endinterface

// File: rtl/ifetch.sv
// ifetch: PC, direct-mapped I-cache with line refill, and BHT/JAL prediction
module ifetch #(
  parameter int ICACHE_LINES = 16,
  parameter int LINE_BYTES = 16,
  parameter int BHT_SIZE = 256
) (
  input logic clk,
  input logic rst,
  input logic rdy,
  input logic rollback,
  input logic [31:0] rollback_pc,
  input logic br_commit,
  input logic [31:0] br_pc,
  input logic br_taken,
  ifetch_if.master bus
);
  localparam int OFF = $clog2(LINE_BYTES);
  localparam int IW = $clog2(ICACHE_LINES);
  localparam int TL = OFF + IW;
  localparam int BW = $clog2(BHT_SIZE);
  typedef enum logic {IDLE, WAIT} state_t;
  state_t state, state_n;
  logic [31:0] pc;
  logic [ICACHE_LINES-1:0] valid;
  logic [31-TL:0] tags [ICACHE_LINES];
  logic [8*LINE_BYTES-1:0] lines [ICACHE_LINES];
  logic [1:0] bht [BHT_SIZE];
  logic [IW-1:0] idx, fill_idx;
  logic [BW-1:0] bi;
  logic [31:0] w, imm_j, imm_b, next_pc;
  logic [1:0] c;
  logic hit, is_jal, is_br, pj, fire, miss, fill;
  logic unused_ok;
  assign idx = pc[TL-1:OFF];
  assign fill_idx = bus.mc_addr[TL-1:OFF];
  assign bi = br_pc[BW+1:2];
  assign c = bht[bi];
  assign hit = valid[idx] && tags[idx] == pc[31:TL];
  assign w = lines[idx][{pc[OFF-1:2], 5'd0} +: 32];
  assign is_jal = w[6:0] == 7'b1101111;
  assign is_br = w[6:0] == 7'b1100011;
  assign pj = is_jal | (is_br & bht[pc[BW+1:2]][1]);
  assign imm_j = {{12{w[31]}}, w[19:12], w[20], w[30:21], 1'b0};
  assign imm_b = {{20{w[31]}}, w[7], w[30:25], w[11:8], 1'b0};
  assign next_pc = pc + (is_jal ? imm_j : pj ? imm_b : 32'd4);
  assign unused_ok = ^{br_pc[31:BW+2], br_pc[1:0], bus.mc_addr[OFF-1:0]};
  always_ff @(posedge clk)
    if (!rst) state <= IDLE;
    else if (rdy) state <= state_n;
  always_comb begin
    state_n = state;
    fire = 1'b0;
    miss = 1'b0;
    fill = 1'b0;
    if (state == IDLE && !rollback) begin
      fire = hit && !bus.issue_stall;
      miss = !hit;
      state_n = hit ? IDLE : WAIT;
    end
    // a refill in flight completes even across a rollback; only the pc is redirected
    if (state == WAIT && bus.mc_done) begin
      fill = 1'b1;
      state_n = IDLE;
    end
  end
  always_ff @(posedge clk)
    if (!rst) begin
      pc <= '0;
      bus.inst_done <= 1'b0;
      bus.inst <= '0;
      bus.inst_pc <= '0;
      bus.pre_j <= 1'b0;
      bus.mc_req <= 1'b0;
      bus.mc_addr <= '0;
      valid <= '0;
      for (int i = 0; i < BHT_SIZE; i++) bht[i] <= 2'b01;
    end else if (rdy) begin
      bus.inst_done <= fire;
      if (rollback) pc <= rollback_pc;
      else if (fire) pc <= next_pc;
      if (fire) begin
        bus.inst <= w;
        bus.inst_pc <= pc;
        bus.pre_j <= pj;
      end
      if (miss) begin
        bus.mc_req <= 1'b1;
        bus.mc_addr <= {pc[31:OFF], {OFF{1'b0}}};
      end
      if (fill) begin
        bus.mc_req <= 1'b0;
        valid[fill_idx] <= 1'b1;
      end
      if (br_commit) bht[bi] <= br_taken ? (c == 2'b11 ? c : c + 2'b01) : (c == 2'b00 ? c : c - 2'b01);
    end
  always_ff @(posedge clk)
    if (rst && rdy && fill) begin
      tags[fill_idx] <= bus.mc_addr[31:TL];
      lines[fill_idx] <= bus.mc_data;
    end
endmodule

// File: tb/tb_ifetch.sv
// tb_ifetch: random program, random stalls/rdy/refill latency, rollbacks and branch commits;
// expected instruction stream comes from an architectural walk of the program.
module tb_ifetch;
  logic clk = 1'b0, rst = 1'b0, rdy = 1'b0, rollback = 1'b0, br_commit = 1'b0, br_taken = 1'b0;
  logic [31:0] rollback_pc = '0, br_pc = '0;
  ifetch_if m ();
  ifetch dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback), .rollback_pc(rollback_pc),
    .br_commit(br_commit), .br_pc(br_pc), .br_taken(br_taken), .bus(m.master)
  );
  always #5 clk = ~clk;
  typedef struct {logic [31:0] pc; logic [31:0] inst; logic pj;} exp_t;
  exp_t exp_q[$];
  logic [31:0] prog [256];
  int kind [256];
  logic [31:0] offs [256];
  int bht_m [256];
  int br_list[$];
  int chk_cnt = 0, pass_cnt = 0, emitted = 0;
  localparam int EPIS = 40;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask
  function automatic logic [31:0] enc_j(input logic [20:0] o);
    return {o[20], o[10:1], o[11], o[19:12], 5'd0, 7'b1101111};
  endfunction
  function automatic logic [31:0] enc_b(input logic [12:0] o, input logic [31:0] r);
    return {o[12], o[10:5], r[24:20], r[19:15], 3'b000, o[4:1], o[11], 7'b1100011};
  endfunction
  function automatic logic [127:0] line_of(input logic [31:0] a);
    logic [7:0] b;
    b = a[9:2];
    return {prog[b + 8'd3], prog[b + 8'd2], prog[b + 8'd1], prog[b]};
  endfunction
  task automatic push_stream(input logic [31:0] start);
    logic [31:0] p;
    exp_t e;
    int k;
    p = start;
    exp_q.delete();
    for (int i = 0; i < 80; i++) begin
      k = int'(p[9:2]);
      e.pc = p;
      e.inst = prog[k];
      e.pj = kind[k] == 1 || (kind[k] == 2 && bht_m[k] >= 2);
      exp_q.push_back(e);
      p = e.pj ? p + offs[k] : p + 32'd4;
    end
  endtask
  initial begin
    logic [31:0] r, o;
    logic [6:0] ops [4];
    ops[0] = 7'b0010011; ops[1] = 7'b0110011; ops[2] = 7'b1100111; ops[3] = 7'b0000011;
    for (int i = 0; i < 256; i++) begin
      r = $urandom;
      kind[i] = ($urandom % 8 == 0) ? 1 : ($urandom % 3 == 0) ? 2 : 0;
      bht_m[i] = 1;
      o = 32'($signed($urandom_range(0, 32)) - 16) <<< 2;
      offs[i] = o;
      prog[i] = kind[i] == 1 ? enc_j(o[20:0]) : kind[i] == 2 ? enc_b(o[12:0], r) : {r[31:7], ops[r[1:0]]};
      if (kind[i] == 2) br_list.push_back(i);
    end
  end
  initial begin : responder
    int cnt = 0;
    m.mc_done = 1'b0;
    m.mc_data = '0;
    forever begin
      @(negedge clk);
      m.mc_done = 1'b0;
      if (rst && m.mc_req === 1'b1) begin
        if (cnt == 0) cnt = $urandom_range(1, 4);
        else begin
          cnt--;
          if (cnt == 0) begin
            m.mc_done = 1'b1;
            m.mc_data = line_of(m.mc_addr);
          end
        end
      end else cnt = 0;
    end
  end
  initial begin : monitor
    exp_t e;
    logic req_prev = 1'b0, done_prev = 1'b0;
    logic [31:0] addr_prev = '0, ipc_prev = '0;
    forever begin
      @(posedge clk);
      #1;
      if (rst && !rdy) begin
        chk("freeze_inst_done", m.inst_done, done_prev);
        chk("freeze_inst_pc", m.inst_pc, ipc_prev);
        chk("freeze_mc_req", m.mc_req, req_prev);
        chk("freeze_mc_addr", m.mc_addr, addr_prev);
      end
      if (rst && rdy && m.inst_done) begin
        if (exp_q.size() == 0) begin
          chk_cnt++;
          $display("FAIL inst_done: unexpected instruction at pc %h, none expected", m.inst_pc);
        end else begin
          e = exp_q.pop_front();
          chk("inst_pc", m.inst_pc, e.pc);
          chk("inst", m.inst, e.inst);
          chk("pre_j", m.pre_j, e.pj);
          emitted++;
        end
      end
      if (rst && rdy && m.mc_req && !req_prev) chk("mc_addr_align", m.mc_addr[3:0], 32'd0);
      req_prev = m.mc_req;
      done_prev = m.inst_done;
      addr_prev = m.mc_addr;
      ipc_prev = m.inst_pc;
    end
  end
  initial begin : driver
    int k;
    logic [31:0] base;
    m.issue_stall = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_inst_done", m.inst_done, 32'd0);
    chk("rst_inst", m.inst, 32'd0);
    chk("rst_inst_pc", m.inst_pc, 32'd0);
    chk("rst_pre_j", m.pre_j, 32'd0);
    chk("rst_mc_req", m.mc_req, 32'd0);
    chk("rst_mc_addr", m.mc_addr, 32'd0);
    push_stream(32'd0);
    rst = 1'b1;
    rdy = 1'b1;
    @(negedge clk);
    chk("first_mc_req", m.mc_req, 32'd1);
    chk("first_mc_addr", m.mc_addr, 32'd0);
    for (int ep = 0; ep < EPIS; ep++) begin
      if (ep > 0) begin
        repeat ($urandom_range(0, 3)) begin
          @(negedge clk);
          rdy = 1'b1;
          m.issue_stall = 1'b1;
          k = br_list[$urandom_range(0, br_list.size() - 1)];
          br_commit = 1'b1;
          br_pc = 32'(k) << 2;
          br_taken = $urandom_range(0, 3) != 0;
          bht_m[k] = br_taken ? (bht_m[k] == 3 ? 3 : bht_m[k] + 1) : (bht_m[k] == 0 ? 0 : bht_m[k] - 1);
        end
        @(negedge clk);
        br_commit = 1'b0;
        rdy = 1'b1;
        m.issue_stall = $urandom_range(0, 1) == 1;
        base = ($urandom_range(0, 3) == 0) ? ($urandom & 32'hFFFFFC00) : 32'd0;
        k = ($urandom_range(0, 2) == 0 && br_list.size() > 0) ? br_list[$urandom_range(0, br_list.size() - 1)] : int'($urandom_range(0, 255));
        rollback_pc = base | (32'(k) << 2);
        rollback = 1'b1;
        push_stream(rollback_pc);
        @(negedge clk);
        rollback = 1'b0;
      end
      repeat ($urandom_range(10, 50)) begin
        @(negedge clk);
        rdy = $urandom_range(0, 9) != 0;
        m.issue_stall = $urandom_range(0, 4) == 0;
      end
    end
    @(negedge clk);
    rdy = 1'b1;
    m.issue_stall = 1'b1;
    repeat (2) @(negedge clk);
    chk("liveness", (emitted >= EPIS * 3) ? 32'd1 : 32'd0, 32'd1);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
